speed_sequencer: RTL
====================

// Module: speed_sequencer
// PURPOSE
//  Glitch-free speed controller for the free-running prescaler. Replaces the combinational
//  divider-bit mux: emits a 1-cycle clock-enable `tick` at one of four rates and changes
//  rate only on a period boundary, through a valid/ready request port.
//  Also emits a free-running 2-bit display-scan phase that rate changes never disturb.
//  Sits between the DIP/button front end and the counting/display logic. Single clock domain.
// PARAMETERS
//  DIV_BIT  22  prescaler width; every TAPn must be in 1..DIV_BIT
//  TAP0     1   sel=0 period = 2^TAP0 cycles
//  TAP1     6   sel=1 period = 2^TAP1 cycles
//  TAP2     16  sel=2 period = 2^TAP2 cycles
//  TAP3     22  sel=3 period = 2^TAP3 cycles
//  SCN_TAP  15  scan phase advances every 2^SCN_TAP cycles
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous reset, active-low
//  req_valid  in   1  rate-change request
//  req_sel    in   2  requested rate index
//  req_ready  out  1  request port can accept (high only in IDLE)
//  tick       out  1  one-cycle enable at the current rate
//  sel_cur    out  2  rate currently in force
//  busy       out  1  switch pending (ARMED or SWITCH)
//  done       out  1  one-cycle pulse: request completed
//  scn        out  2  display scan phase
//  hold       in   1  present only with SPEED_SEQ_HOLD_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): cnt=0, scn_cnt=0, sel_cur=0, tick=0, done=0, busy=0,
//   req_ready=1, state=IDLE. A pending request is dropped.
//  Prescaler cnt[DIV_BIT-1:0]: +1 per cycle, wraps modulo 2^DIV_BIT.
//   Cleared to 0 in the SWITCH cycle only.
//  tick (registered) = 1 in the cycle after cnt[TAPsel-1:0] == all ones, where sel=sel_cur.
//   Period is exactly 2^TAPsel cycles. First tick after reset comes 2^TAP0 cycles after release.
//  scn = scn_cnt[SCN_TAP+1:SCN_TAP] of a separate free-running counter.
//   Never cleared by a rate switch; wraps 3->0.
//  FSM:
//   IDLE:   req_ready=1. On req_valid && req_sel==sel_cur: done=1 next cycle, stay IDLE,
//           cnt unaffected. On req_valid && req_sel!=sel_cur: latch req_sel -> ARMED.
//   ARMED:  busy=1, req_ready=0. Wait for the old-rate boundary
//           (cnt[TAPsel-1:0] all ones) -> SWITCH. That final old-rate tick is still emitted.
//   SWITCH: one cycle. sel_cur<=latched sel, cnt<=0, done=1 next cycle -> IDLE.
//           First new-rate tick comes exactly 2^TAPnew cycles after the SWITCH cycle.
//  Request accept latency: 1 cycle. Switch latency: at most 2^TAPold+2 cycles.
//  No tick is ever shortened or duplicated across a switch.
//  req_valid while req_ready=0 is ignored; the requester holds it until ready.
//  Accept coinciding with a boundary: the tick is emitted, and the FSM still waits
//   for the next full boundary.
//  Mid-operation reset: all state returns to reset values immediately (async).
// CONFIGURATION
//  SPEED_SEQ_HOLD_EN defined: input `hold` is added.
//   hold=1 freezes cnt and forces tick=0. The FSM stays in ARMED while frozen.
//   scn_cnt keeps running so the display still scans. Release resumes from the frozen cnt.
//  Not defined: no `hold` port; cnt always counts.
// TESTING
//  1 Release reset, no requests -> tick every 2 cycles, sel_cur=0, scn steps every 32768 cycles.
//  2 Req sel=1 in IDLE -> ready drops, busy=1 until the next sel0 boundary.
//    sel_cur=1, done pulse, next tick exactly 64 cycles after SWITCH.
//  3 Req sel=1 while sel_cur=1 -> done after 1 cycle, no busy, tick phase unchanged.
//  4 Override TAP3=8. Switch 0->3, then request 3->0 mid-period ->
//    remaining 256-cycle period completes, then a tick every 2 cycles.
//  5 rst_n=0 while ARMED -> outputs at reset values immediately. Request lost, sel_cur=0.
//  6 SPEED_SEQ_HOLD_EN: hold=1 for 100 cycles in ARMED -> no ticks, no switch, scn advances.
//    Release -> switch at the next boundary.

Source files
------------

// File: rtl/speed_sequencer.sv
// speed_sequencer: glitch-free 4-rate tick generator with boundary-aligned rate switching and free-running scan phase.
// Optional SPEED_SEQ_HOLD_EN adds a hold input that freezes the prescaler and suppresses ticks.
module speed_sequencer #(
  parameter int DIV_BIT = 22,
  parameter int TAP0    = 1,
  parameter int TAP1    = 6,
  parameter int TAP2    = 16,
  parameter int TAP3    = 22,
  parameter int SCN_TAP = 15
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef SPEED_SEQ_HOLD_EN
  input  logic       hold,
`endif
  input  logic       req_valid,
  input  logic [1:0] req_sel,
  output logic       req_ready,
  output logic       tick,
  output logic [1:0] sel_cur,
  output logic       busy,
  output logic       done,
  output logic [1:0] scn
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] SWITCH = 2'd2;
  localparam logic [DIV_BIT-1:0] ONES = '1;
  localparam logic [DIV_BIT-1:0] M0 = ONES >> (DIV_BIT - TAP0);
  localparam logic [DIV_BIT-1:0] M1 = ONES >> (DIV_BIT - TAP1);
  localparam logic [DIV_BIT-1:0] M2 = ONES >> (DIV_BIT - TAP2);
  localparam logic [DIV_BIT-1:0] M3 = ONES >> (DIV_BIT - TAP3);
  logic [1:0]         state_q, state_d, sel_q, sel_d, pend_q, pend_d;
  logic [DIV_BIT-1:0] cnt_q, cnt_d, mask;
  logic [SCN_TAP+1:0] scn_q, scn_d;
  logic               tick_q, tick_d, done_q, done_d, run, bnd;
`ifdef SPEED_SEQ_HOLD_EN
  assign run = !hold;
`else
  assign run = 1'b1;
`endif
  assign mask = sel_q == 2'd0 ? M0 : sel_q == 2'd1 ? M1 : sel_q == 2'd2 ? M2 : M3;
  assign bnd  = run && ((cnt_q & mask) == mask);
  // Clearing cnt as ARMED leaves makes the SWITCH cycle count 0, so the
  // first new-rate tick lands exactly one new period after SWITCH.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    cnt_d   = run ? cnt_q + 1'b1 : cnt_q;
    tick_d  = bnd;
    scn_d   = scn_q + 1'b1;
    if (state_q == IDLE && req_valid) begin
      if (req_sel == sel_q) done_d = 1'b1;
      else begin
        pend_d  = req_sel;
        state_d = ARMED;
      end
    end
    if (state_q == ARMED && bnd) begin
      state_d = SWITCH;
      cnt_d   = '0;
    end
    if (state_q == SWITCH) begin
      sel_d   = pend_q;
      done_d  = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      pend_q  <= 2'd0;
      cnt_q   <= '0;
      scn_q   <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      scn_q   <= scn_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign tick      = tick_q;
  assign done      = done_q;
  assign sel_cur   = sel_q;
  assign scn       = scn_q[SCN_TAP+1:SCN_TAP];
endmodule
